// File: rtl/piso_tx_scheduler.sv
// Sequencing controller for an 8-bit PISO: round-robin arbitration between two
// valid/ready requesters, load strobe generation and shift/gap window timing.
module piso_tx_scheduler #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             piso_load,
  output logic [WIDTH-1:0] piso_data,
  output logic             tx_active,
  output logic             tx_src,
  output logic             tx_done
);

  localparam int CNT_MAX = (WIDTH > 15) ? WIDTH : 15;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHIFT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_grant;
  logic          grant;
  logic          accept;

  // With both valid the requester not served last time wins; last_grant
  // resets to 1 so req0 is favoured first.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
  end

  assign accept = req0_ready | req1_ready;

  // State register. The counter reloads on every state entry and counts down
  // to zero, which marks the final cycle of SHIFT or GAP.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: both combinational outputs get defaults first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_SHIFT;
        cnt_nxt   = SHIFT_LOAD;
      end
      ST_SHIFT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (GAP == 0) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Ready is gated by rst so the handshake is dead while reset is held, even
  // though the state register already reads IDLE.
  always_comb begin
    req0_ready = rst && (state == ST_IDLE) && req0_valid && !grant;
    req1_ready = rst && (state == ST_IDLE) && req1_valid &&  grant;
    piso_load  = (state == ST_LOAD);
    tx_active  = (state == ST_LOAD) || (state == ST_SHIFT);
    tx_done    = (state == ST_SHIFT) && (cnt == '0);
  end

  // Hold register: word and source captured only on an accepted handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      piso_data  <= '0;
      tx_src     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      piso_data  <= grant ? req1_data : req0_data;
      tx_src     <= grant;
      last_grant <= grant;
    end
  end

endmodule

// File: doc/piso_tx_scheduler.md
# piso_tx_scheduler

Sequencing controller for the 8-bit parallel-in/serial-out shift register. It arbitrates between two byte requesters with valid/ready handshakes, using round-robin priority. It drives the PISO's `load` and `parallel_in` lines and times each word's shift-out window. It reports the active source and a per-word completion strobe so downstream logic can frame the serial stream.

## Interface
- `WIDTH`, default 8: word width, equal to the PISO width.
- `GAP`, default 1: idle cycles inserted after each word (legal 0..15).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req0_valid`  in  1: requester 0 has a word.
- `req0_data`  in  WIDTH: requester 0 word.
- `req0_ready`  out  1: requester 0 word accepted this cycle when `req0_valid` is also high.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `piso_load`  out  1: one-cycle load strobe to the PISO.
- `piso_data`  out  WIDTH: word presented to the PISO parallel input.
- `tx_active`  out  1: high while a word is being loaded or shifted.
- `tx_src`  out  1: index of the requester owning the current or last word.
- `tx_done`  out  1: one-cycle pulse on the last shift cycle of a word.

## Operation
States and transitions:
- IDLE: leave when a handshake completes (either `reqN_valid & reqN_ready`), go to LOAD.
- LOAD: always lasts 1 cycle, then go to SHIFT.
- SHIFT: lasts WIDTH cycles, then go to GAP, or to IDLE if GAP = 0.
- GAP: lasts GAP cycles, then go to IDLE.

Arbitration:
- Combinational grant, evaluated only in IDLE.
- If exactly one requester is valid, it wins.
- If both are valid, the requester not granted last time wins.
- `reqN_ready` = (state == IDLE) & (grant == N). A ready output never asserts outside IDLE, and never for a non-winning requester.
- The round-robin pointer updates only on an accepted handshake.
- After reset the pointer favours req0.

Data path:
- On acceptance, `reqN_data` is captured into the hold register that drives `piso_data`. `tx_src` is set to N.
- `piso_data` and `tx_src` hold their values until the next acceptance.
- A valid that drops while in IDLE without a handshake causes no action.
- Data and valid changes outside IDLE are ignored.

Output decoding:
- `piso_load` is high only in LOAD.
- `tx_active` is high in LOAD and SHIFT.
- `tx_done` is high only in the final SHIFT cycle.

Counter: a single down-counter, wide enough for max(WIDTH, 15), times both the SHIFT and GAP states. It reloads on every state entry.

Reset behaviour:
- Asserting `rst` low at any point, including mid-SHIFT, forces IDLE immediately.
- Reset values: all outputs 0, counter 0, pointer favouring req0.
- A word interrupted by reset is dropped and produces no `tx_done`.

## Timing
- Define cycle 0 as the IDLE cycle with a completed handshake.
- Cycle 1: `piso_load` = 1, with the new `piso_data`.
- Cycles 2..WIDTH+1: SHIFT.
- Cycle WIDTH+1: `tx_done` = 1.
- Cycles WIDTH+2..WIDTH+GAP+1: GAP.
- Cycle WIDTH+GAP+2: IDLE, and ready may assert again.
- Back-to-back word period is WIDTH+GAP+2 cycles; with the defaults this is 11.
- Ready is combinational from the registered state and the current valids. It has no same-cycle dependency on ready from the requester side.
- Every output except the ready signals is a registered value or a decode of registered state.

## Test plan
- Reset and hold: with `rst` low, toggle both valids. Required: both ready 0, `piso_load` 0, `piso_data` 0x00, `tx_done` 0.
- Single word: release reset, then `req0_valid` = 1 with 0xCB at cycle 0. Required:
  - `req0_ready` = 1 at cycle 0.
  - `piso_load` = 1 and `piso_data` = 0xCB at cycle 1 only.
  - `tx_done` at cycle 9.
  - `req0_ready` = 1 again at cycle 11 if valid is still high.
- Round robin: hold both valids with 0xA5 (req0) and 0x3C (req1). Required: loads alternate 0xA5, 0x3C, 0xA5, with `tx_src` = 0, 1, 0, and load strobes 11 cycles apart.
- Single requester streaming: hold only `req1_valid` for three words. Required: req1 granted on all three, `tx_src` = 1 throughout, and no idle grant to req0.
- GAP = 0 build: back-to-back words with `req0_valid` held. Required: `piso_load` pulses every 10 cycles, and `tx_done` is high in the cycle just before IDLE.
- Reset mid-shift: drop `rst` at cycle 5 of a word. Required: immediate return to IDLE, outputs 0, no `tx_done`. After release, a pending req0 and req1 pair grants req0 first.
